// File: rtl/alu_ctrl_if.sv
// Issue / ALU / writeback signal bundle for alu_ctrl.
// slave is the controller's view; master is the surrounding pipeline's view.
interface alu_ctrl_if;
  logic        iInstrValid;
  logic        oInstrRdy;
  logic [31:0] iInstr;
  logic [31:0] iRs1Data;
  logic [31:0] iRs2Data;
  logic [3:0]  oAluOP;
  logic [31:0] oAluA;
  logic [31:0] oAluB;
  logic        iAluRdy;
  logic [31:0] iAluC;
  logic        oWbValid;
  logic        iWbRdy;
  logic [4:0]  oWbRd;
  logic [31:0] oWbData;
  logic        oIllegal;

  modport slave (
    input  iInstrValid, iInstr, iRs1Data, iRs2Data, iAluRdy, iAluC, iWbRdy,
    output oInstrRdy, oAluOP, oAluA, oAluB, oWbValid, oWbRd, oWbData, oIllegal
  );

  modport master (
    output iInstrValid, iInstr, iRs1Data, iRs2Data, iAluRdy, iAluC, iWbRdy,
    input  oInstrRdy, oAluOP, oAluA, oAluB, oWbValid, oWbRd, oWbData, oIllegal
  );
endinterface

// File: rtl/alu_ctrl.sv
// RV32I issue/decode controller: decodes R-type (and, with ALU_CTRL_OPIMM_EN
// defined, OP-IMM) instructions, drives the ALU and returns the result to writeback.
module alu_ctrl (
  input logic       iClk,
  input logic       nRst,
  alu_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0, OP_SUB = 4'd1, OP_XOR = 4'd2, OP_OR  = 4'd3, OP_AND  = 4'd4,
    OP_SLL  = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7, OP_SLT = 4'd8, OP_SLTU = 4'd9
  } alu_op_t;

  typedef struct packed {
    logic        legal;
    alu_op_t     op;
    logic [31:0] b;
  } decode_t;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
`ifdef ALU_CTRL_OPIMM_EN
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
`endif

  state_t      state, state_nxt;
  decode_t     dec;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic        unused_rs_fields;

  alu_op_t     alu_op_q;
  logic [31:0] alu_a_q, alu_b_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;
  logic        illegal_q;

  assign instr            = bus.iInstr;
  assign opcode           = instr[6:0];
  assign funct3           = instr[14:12];
  assign funct7           = instr[31:25];
  assign unused_rs_fields = ^instr[24:15];

  // NOTE: every field gets a default before the case so no path leaves a latch.
  always_comb begin
    dec.legal = 1'b0;
    dec.op    = OP_ADD;
    dec.b     = bus.iRs2Data;
    if (opcode == OPC_OP) begin
      case (funct3)
        3'b000: begin
          dec.legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          dec.op    = (funct7 == F7_ALT) ? OP_SUB : OP_ADD;
        end
        3'b001: begin dec.legal = (funct7 == F7_BASE); dec.op = OP_SLL;  end
        3'b010: begin dec.legal = (funct7 == F7_BASE); dec.op = OP_SLT;  end
        3'b011: begin dec.legal = (funct7 == F7_BASE); dec.op = OP_SLTU; end
        3'b100: begin dec.legal = (funct7 == F7_BASE); dec.op = OP_XOR;  end
        3'b101: begin
          dec.legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          dec.op    = (funct7 == F7_ALT) ? OP_SRA : OP_SRL;
        end
        3'b110: begin dec.legal = (funct7 == F7_BASE); dec.op = OP_OR;   end
        default: begin dec.legal = (funct7 == F7_BASE); dec.op = OP_AND; end
      endcase
    end
`ifdef ALU_CTRL_OPIMM_EN
    else if (opcode == OPC_OPIMM) begin
      dec.legal = 1'b1;
      dec.b     = {{20{instr[31]}}, instr[31:20]};
      case (funct3)
        3'b000: dec.op = OP_ADD;
        3'b001: begin
          dec.legal = (funct7 == F7_BASE);
          dec.op    = OP_SLL;
          dec.b     = {27'd0, instr[24:20]};
        end
        3'b010: dec.op = OP_SLT;
        3'b011: dec.op = OP_SLTU;
        3'b100: dec.op = OP_XOR;
        3'b101: begin
          // Shift immediates carry only the 5-bit shamt; funct7 picks logical vs arithmetic.
          dec.legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          dec.op    = (funct7 == F7_ALT) ? OP_SRA : OP_SRL;
          dec.b     = {27'd0, instr[24:20]};
        end
        3'b110: dec.op = OP_OR;
        default: dec.op = OP_AND;
      endcase
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments under an async active-low reset.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.iInstrValid) state_nxt = dec.legal ? EXEC : RESP;
      EXEC:    if (bus.iAluRdy)     state_nxt = RESP;
      RESP:    if (bus.iWbRdy)      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ready is forced low while reset is held even though the state already reads IDLE.
  always_comb begin
    bus.oInstrRdy = 1'b0;
    bus.oWbValid  = 1'b0;
    case (state)
      IDLE:    bus.oInstrRdy = nRst;
      RESP:    bus.oWbValid  = 1'b1;
      default: ;
    endcase
  end

  // Illegal instructions leave the ALU-facing registers untouched and return zero.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      alu_op_q  <= OP_ADD;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (state == IDLE && bus.iInstrValid) begin
        wb_rd_q   <= instr[11:7];
        illegal_q <= !dec.legal;
        if (dec.legal) begin
          alu_op_q <= dec.op;
          alu_a_q  <= bus.iRs1Data;
          alu_b_q  <= dec.b;
        end else begin
          wb_data_q <= '0;
        end
      end
      if (state == EXEC && bus.iAluRdy) wb_data_q <= bus.iAluC;
    end
  end

  assign bus.oAluOP   = alu_op_q;
  assign bus.oAluA    = alu_a_q;
  assign bus.oAluB    = alu_b_q;
  assign bus.oWbRd    = wb_rd_q;
  assign bus.oWbData  = wb_data_q;
  assign bus.oIllegal = illegal_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: directed instructions against a decode-table
// model, with a per-cycle compare process on the ALU and writeback outputs.
module tb_alu_ctrl;

  logic iClk = 1'b0;
  logic nRst = 1'b0;
  always #5 iClk = ~iClk;

  alu_ctrl_if bus ();
  alu_ctrl dut (.iClk(iClk), .nRst(nRst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model of what the outputs must show: last issued ALU request and pending writeback.
  logic [3:0]  m_op = '0;
  logic [31:0] m_a = '0, m_b = '0, m_data = '0;
  logic [4:0]  m_rd = '0;
  logic        m_illegal = 1'b0;
  bit          mon_en = 1'b0;

  // Legal R-type combinations: {funct7, funct3, alu op}.
  localparam logic [13:0] R_TABLE [10] = '{
    {7'h00, 3'b000, 4'd0}, {7'h20, 3'b000, 4'd1}, {7'h00, 3'b001, 4'd5},
    {7'h00, 3'b010, 4'd8}, {7'h00, 3'b011, 4'd9}, {7'h00, 3'b100, 4'd2},
    {7'h00, 3'b101, 4'd6}, {7'h20, 3'b101, 4'd7}, {7'h00, 3'b110, 4'd3},
    {7'h00, 3'b111, 4'd4}
  };

  function automatic void model_decode(input logic [31:0] instr, input logic [31:0] rs1,
                                       input logic [31:0] rs2, output bit legal,
                                       output logic [3:0] op, output logic [31:0] a,
                                       output logic [31:0] b);
    legal = 0; op = 4'd0; a = rs1; b = rs2;
    if (instr[6:0] == 7'b0110011) begin
      for (int i = 0; i < 10; i++)
        if (R_TABLE[i][13:4] == {instr[31:25], instr[14:12]}) begin
          legal = 1; op = R_TABLE[i][3:0];
        end
    end
`ifdef ALU_CTRL_OPIMM_EN
    else if (instr[6:0] == 7'b0010011) begin
      b = {{20{instr[31]}}, instr[31:20]};
      case (instr[14:12])
        3'b000: begin legal = 1; op = 4'd0; end
        3'b010: begin legal = 1; op = 4'd8; end
        3'b011: begin legal = 1; op = 4'd9; end
        3'b100: begin legal = 1; op = 4'd2; end
        3'b110: begin legal = 1; op = 4'd3; end
        3'b111: begin legal = 1; op = 4'd4; end
        3'b001: begin legal = (instr[31:25] == 7'h00); op = 4'd5; b = 32'(instr[24:20]); end
        default: begin
          legal = (instr[31:25] == 7'h00) || (instr[31:25] == 7'h20);
          op    = (instr[31:25] == 7'h20) ? 4'd7 : 4'd6;
          b     = 32'(instr[24:20]);
        end
      endcase
    end
`endif
  endfunction

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  // Compare process: ALU outputs always equal the last issue; writeback checked while valid.
  always @(negedge iClk) begin
    if (mon_en && nRst) begin
      check("cmp_alu_op", 32'(bus.oAluOP), 32'(m_op));
      check("cmp_alu_a", bus.oAluA, m_a);
      check("cmp_alu_b", bus.oAluB, m_b);
      if (bus.oWbValid) begin
        check("cmp_wb_rd", 32'(bus.oWbRd), 32'(m_rd));
        check("cmp_wb_data", bus.oWbData, m_data);
        check("cmp_illegal", 32'(bus.oIllegal), 32'(m_illegal));
      end
    end
  end

  task automatic check_zero(input string pfx);
    check({pfx, "_rdy"}, 32'(bus.oInstrRdy), 0);
    check({pfx, "_op"}, 32'(bus.oAluOP), 0);
    check({pfx, "_a"}, bus.oAluA, 0);
    check({pfx, "_b"}, bus.oAluB, 0);
    check({pfx, "_wbv"}, 32'(bus.oWbValid), 0);
    check({pfx, "_rd"}, 32'(bus.oWbRd), 0);
    check({pfx, "_data"}, bus.oWbData, 0);
    check({pfx, "_ill"}, 32'(bus.oIllegal), 0);
  endtask

  // One full transaction; entered and left just after a falling edge.
  task automatic issue(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2,
                       input int alu_low, input int wb_low, input logic [31:0] token);
    bit          legal;
    logic [3:0]  op;
    logic [31:0] a, b;
    int          lat, waited;
    model_decode(instr, rs1, rs2, legal, op, a, b);
    bus.iInstr      = instr;
    bus.iRs1Data    = rs1;
    bus.iRs2Data    = rs2;
    bus.iInstrValid = 1'b1;
    bus.iAluRdy     = (alu_low == 0);
    bus.iAluC       = (alu_low == 0) ? token : ~token;
    waited = 0;
    while (!bus.oInstrRdy && waited < 20) begin @(negedge iClk); waited++; end
    check("accept_rdy", 32'(bus.oInstrRdy), 1);
    if (!bus.oInstrRdy) return;
    @(posedge iClk);
    #1;
    if (legal) begin m_op = op; m_a = a; m_b = b; m_data = token; end
    else m_data = '0;
    m_rd      = instr[11:7];
    m_illegal = !legal;
    // Keep offering a different instruction while busy; it must be ignored.
    bus.iInstr   = rtype(7'h00, 5'd2, 5'd1, 3'b111, 5'd31);
    bus.iRs1Data = 32'hDEAD_BEEF;
    bus.iRs2Data = 32'hFFFF_FFFF;
    lat = 0;
    do begin
      @(negedge iClk);
      lat++;
      if (!bus.oWbValid) begin
        check("busy_rdy", 32'(bus.oInstrRdy), 0);
        if (lat == alu_low + 1) begin bus.iAluRdy = 1'b1; bus.iAluC = token; end
      end
    end while (!bus.oWbValid && lat < 40);
    check("wb_latency", 32'(lat), legal ? 32'(alu_low + 2) : 32'd1);
    if (!bus.oWbValid) return;
    bus.iAluC  = token ^ 32'h5A5A_5A5A;
    bus.iWbRdy = (wb_low == 0);
    for (int j = 1; j <= wb_low; j++) begin
      @(negedge iClk);
      check("wb_hold", 32'(bus.oWbValid), 1);
      check("resp_rdy", 32'(bus.oInstrRdy), 0);
      bus.iAluC = bus.iAluC + 32'd1;
      if (j == wb_low) bus.iWbRdy = 1'b1;
    end
    @(negedge iClk);
    check("wb_drop", 32'(bus.oWbValid), 0);
    check("idle_rdy", 32'(bus.oInstrRdy), 1);
    bus.iWbRdy      = 1'b0;
    bus.iInstrValid = 1'b0;
    bus.iAluRdy     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          lg;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [4:0]  misc_f3 [5] = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b111};
    logic [4:0]  misc_rd [5] = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd0};

    bus.iInstrValid = 1'b0; bus.iInstr = '0; bus.iRs1Data = '0; bus.iRs2Data = '0;
    bus.iAluRdy = 1'b0; bus.iAluC = '0; bus.iWbRdy = 1'b0;

    repeat (2) @(negedge iClk);
    check_zero("rst");
    nRst = 1'b1;
    #1;
    check("rst_release_rdy", 32'(bus.oInstrRdy), 1);
    mon_en = 1'b1;

    // add x3, x1, x2 with 5 + 7
    issue(rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'd5, 32'd7, 0, 0, 32'd12);
    check("lit_add_op", 32'(bus.oAluOP), 32'd0);
    check("lit_add_a", bus.oAluA, 32'd5);
    check("lit_add_b", bus.oAluB, 32'd7);

    // sub then sra back to back
    issue(rtype(7'h20, 5'd2, 5'd1, 3'b000, 5'd4), 32'd100, 32'd30, 0, 0, 32'd70);
    check("lit_sub_op", 32'(bus.oAluOP), 32'd1);
    issue(rtype(7'h20, 5'd2, 5'd1, 3'b101, 5'd5), 32'h8000_0000, 32'd4, 0, 0, 32'hF800_0000);
    check("lit_sra_op", 32'(bus.oAluOP), 32'd7);
    check("lit_sra_b", bus.oAluB, 32'd4);

    // ALU stall of 4 cycles, then writeback stall of 3 cycles
    issue(rtype(7'h00, 5'd2, 5'd1, 3'b100, 5'd6), 32'h0000_F0F0, 32'h0000_0FF0, 4, 0, 32'h0000_FF00);
    check("lit_xor_op", 32'(bus.oAluOP), 32'd2);
    issue(rtype(7'h00, 5'd2, 5'd1, 3'b110, 5'd7), 32'h1234_0000, 32'h0000_5678, 0, 3, 32'h1234_5678);
    check("lit_or_op", 32'(bus.oAluOP), 32'd3);

    // Remaining R-type ops; the last one targets x0
    for (int i = 0; i < 5; i++)
      issue(rtype(7'h00, 5'd2, 5'd1, misc_f3[i][2:0], misc_rd[i]),
            32'hFFFF_0000 + 32'(i), 32'h00FF_FF00 + 32'(i), i % 2, i % 3, 32'hA000_0000 + 32'(i));
    check("lit_and_op", 32'(bus.oAluOP), 32'd4);
    check("lit_and_a", bus.oAluA, 32'hFFFF_0004);

    // Illegal: mul, sll with funct7=0100000, unsupported opcode
    issue(rtype(7'h01, 5'd2, 5'd1, 3'b000, 5'd8), 32'd3, 32'd9, 0, 1, 32'h0000_001B);
    check("lit_mul_op_kept", 32'(bus.oAluOP), 32'd4);
    check("lit_mul_a_kept", bus.oAluA, 32'hFFFF_0004);
    issue(rtype(7'h20, 5'd2, 5'd1, 3'b001, 5'd9), 32'd1, 32'd2, 0, 0, 32'h1111_1111);
    issue({20'hABCDE, 5'd9, 7'b0110111}, 32'd1, 32'd2, 0, 0, 32'h2222_2222);
    check("lit_lui_b_kept", bus.oAluB, 32'h00FF_FF04);

    // addi x9, x1, -1
    issue(itype(12'hFFF, 5'd1, 3'b000, 5'd9), 32'd10, 32'h5555_5555, 0, 0, 32'd9);
`ifdef ALU_CTRL_OPIMM_EN
    check("lit_addi_op", 32'(bus.oAluOP), 32'd0);
    check("lit_addi_b", bus.oAluB, 32'hFFFF_FFFF);
    check("lit_addi_a", bus.oAluA, 32'd10);
    issue(itype({7'h20, 5'd3}, 5'd1, 3'b101, 5'd10), 32'hF000_0000, 32'd0, 1, 0, 32'hFE00_0000);
    check("lit_srai_op", 32'(bus.oAluOP), 32'd7);
    check("lit_srai_b", bus.oAluB, 32'd3);
    issue(itype({7'h20, 5'd3}, 5'd1, 3'b001, 5'd11), 32'd1, 32'd0, 0, 0, 32'h3333_3333);
    check("lit_slli_bad_kept", bus.oAluB, 32'd3);
`else
    check("lit_addi_kept_op", 32'(bus.oAluOP), 32'd4);
    check("lit_addi_kept_b", bus.oAluB, 32'h00FF_FF04);
`endif

    // Reset pulsed while in EXEC
    model_decode(rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd6), 32'd11, 32'd22, lg, op, a, b);
    bus.iInstr = rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd6);
    bus.iRs1Data = 32'd11; bus.iRs2Data = 32'd22;
    bus.iInstrValid = 1'b1; bus.iAluRdy = 1'b0;
    @(posedge iClk);
    #1;
    m_op = op; m_a = a; m_b = b; m_rd = 5'd6;
    bus.iInstrValid = 1'b0;
    @(negedge iClk);
    check("mid_exec_rdy", 32'(bus.oInstrRdy), 0);
    check("mid_exec_a", bus.oAluA, 32'd11);
    #2 nRst = 1'b0;
    #1;
    check_zero("mid_rst");
    m_op = '0; m_a = '0; m_b = '0; m_rd = '0; m_data = '0; m_illegal = 1'b0;
    repeat (2) @(negedge iClk);
    nRst = 1'b1;
    #1;
    check("mid_rst_release_rdy", 32'(bus.oInstrRdy), 1);
    issue(rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd7), 32'd1, 32'd2, 0, 0, 32'd3);
    check("lit_post_rst_a", bus.oAluA, 32'd1);

    repeat (2) @(negedge iClk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
